// File: rtl/bitwise_logic_pipe_if.sv
// Streaming handshake bundle for bitwise_logic_pipe: operand/op request side and
// FIFO result side, each with valid/ready.
interface bitwise_logic_pipe_if #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_chain;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_red_and;
  logic             out_red_or;
  logic             out_parity;
  logic [CntW-1:0]  out_count;

  modport master (
    output in_valid, in_op, in_a, in_b, in_chain, acc_clr, out_ready,
    input  in_ready, out_valid, out_y, out_red_and, out_red_or, out_parity, out_count
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_chain, acc_clr, out_ready,
    output in_ready, out_valid, out_y, out_red_and, out_red_or, out_parity, out_count
  );
endinterface

// File: rtl/bitwise_logic_pipe.sv
// Bitwise op unit with optional accumulator chaining, buffered through a
// DEPTH-entry output FIFO with valid/ready on both sides.
module bitwise_logic_pipe #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  bitwise_logic_pipe_if.slave bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] result;
  logic             push;
  logic             pop;
  logic             not_empty;
  logic [WIDTH-1:0] head;

  always_comb begin
    op_a   = bus.in_chain ? acc_q : bus.in_a;
    result = '0;
    case (bus.in_op)
      3'd0:    result = op_a & bus.in_b;
      3'd1:    result = op_a | bus.in_b;
      3'd2:    result = op_a ^ bus.in_b;
      3'd3:    result = ~(op_a & bus.in_b);
      3'd4:    result = ~(op_a | bus.in_b);
      3'd5:    result = ~(op_a ^ bus.in_b);
      3'd6:    result = op_a & ~bus.in_b;
      default: result = op_a;
    endcase
  end

  // Ready depends only on registered occupancy: a full FIFO never bypasses.
  assign not_empty = (count_q != '0);
  assign push      = bus.in_valid && (count_q != Full);
  assign pop       = not_empty && bus.out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    acc_d    = acc_q;

    if (push) begin
      mem_d[wr_ptr_q] = result;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
      acc_d           = result;
    end else if (bus.acc_clr) begin
      acc_d = '0;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
    end
  end

  // Empty FIFO presents zeros rather than whatever the head slot last held.
  assign head            = not_empty ? mem_q[rd_ptr_q] : '0;
  assign bus.in_ready    = (count_q != Full);
  assign bus.out_valid   = not_empty;
  assign bus.out_y       = head;
  assign bus.out_red_and = not_empty & (&head);
  assign bus.out_red_or  = |head;
  assign bus.out_parity  = ^head;
  assign bus.out_count   = count_q;
endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Self-checking bench for bitwise_logic_pipe: vector table plus hand sequences,
// with a queue scoreboard checking every cycle at the falling edge.
module tb_bitwise_logic_pipe;
  localparam int unsigned W = 2;
  localparam int unsigned D = 2;

  logic clk;
  logic rst_n;

  bitwise_logic_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();

  bitwise_logic_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;
  logic [W-1:0] sb[$];
  logic [W-1:0] drv_exp;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         chain;
    logic         clr;
    logic         gap;
    logic [W-1:0] y;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a & ~b;
      default: return a;
    endcase
  endfunction

  // Scoreboard: model occupancy is the queue size; decisions use the model, not the DUT.
  always @(negedge clk) begin
    int sz;
    if (!rst_n) begin
      sb.delete();
    end else begin
      sz = sb.size();
      check("count", 32'(bus.out_count), 32'(sz));
      check("in_ready", 32'(bus.in_ready), 32'(sz != D));
      check("out_valid", 32'(bus.out_valid), 32'(sz != 0));
      if (sz == 0) begin
        check("y_empty", 32'(bus.out_y), 32'd0);
        check("red_empty", 32'({bus.out_red_and, bus.out_red_or, bus.out_parity}), 32'd0);
      end else begin
        check("y", 32'(bus.out_y), 32'(sb[0]));
        check("red", 32'({bus.out_red_and, bus.out_red_or, bus.out_parity}),
              32'({&sb[0], |sb[0], ^sb[0]}));
      end
      if (sz != 0 && bus.out_ready) void'(sb.pop_front());
      if (bus.in_valid && sz != D) sb.push_back(drv_exp);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid still high.
  task automatic push(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic chain, input logic clr, input logic [W-1:0] exp);
    logic got;
    got          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_chain = chain;
    bus.acc_clr  = clr;
    drv_exp      = exp;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.acc_clr = 1'b0;
    check("push_accept", 32'(got), 32'd1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_chain = 1'b0;
    bus.acc_clr  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 50 && bus.out_count != 0; i++) @(negedge clk);
    check("drain", 32'(bus.out_count), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    drv_exp = '0;
    // op, a, b, chain, clr, gap, y
    vecs[0]  = '{3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[1]  = '{3'd0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[2]  = '{3'd0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[3]  = '{3'd0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 2'b10};
    vecs[4]  = '{3'd0, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0, 2'b10};
    vecs[5]  = '{3'd1, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0, 2'b11};
    vecs[6]  = '{3'd2, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0, 2'b01};
    vecs[7]  = '{3'd3, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0, 2'b01};
    vecs[8]  = '{3'd4, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[9]  = '{3'd5, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0, 2'b10};
    vecs[10] = '{3'd6, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[11] = '{3'd7, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0, 2'b10};
    vecs[12] = '{3'd0, 2'b11, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10};
    vecs[13] = '{3'd1, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 2'b11};
    vecs[14] = '{3'd2, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[15] = '{3'd1, 2'b11, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_chain  = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b1;

    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_y", 32'(bus.out_y), 32'd0);
    check("rst_count", 32'(bus.out_count), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: single-shot AND vectors, back-to-back op sweep, chain sequence.
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].clr) begin
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b1;
        @(posedge clk);
        #1;
        bus.acc_clr = 1'b0;
      end
      push(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].chain, 1'b0, vecs[i].y);
      if (vecs[i].gap) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("latency_valid", 32'(bus.out_valid), 32'd1);
        check("latency_y", 32'(bus.out_y), 32'(vecs[i].y));
        @(posedge clk);
        #1;
      end
      if (i == 3 || i == 11) drain();
    end
    drain();

    // Clear coinciding with accept: accept wins, next chain sees the new result.
    push(3'd7, 2'b01, 2'b00, 1'b0, 1'b1, 2'b01);
    push(3'd7, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01);
    drain();

    // Backpressure: third push stalls at full until out_ready rises.
    bus.out_ready = 1'b0;
    push(3'd0, 2'b11, 2'b01, 1'b0, 1'b0, ref_op(3'd0, 2'b11, 2'b01));
    push(3'd2, 2'b11, 2'b01, 1'b0, 1'b0, ref_op(3'd2, 2'b11, 2'b01));
    fork
      push(3'd4, 2'b01, 2'b00, 1'b0, 1'b0, ref_op(3'd4, 2'b01, 2'b00));
      begin
        repeat (3) @(negedge clk);
        check("full_stall_ready", 32'(bus.in_ready), 32'd0);
        check("full_count", 32'(bus.out_count), 32'd2);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Simultaneous push/pop at count 1 across pointer wrap.
    push(3'd7, 2'b11, 2'b00, 1'b0, 1'b0, 2'b11);
    for (int i = 0; i < 8; i++) begin
      push(3'd7, 2'(i), 2'b11, 1'b0, 1'b0, ref_op(3'd7, 2'(i), 2'b11));
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("pp_count", 32'(bus.out_count), 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Asynchronous reset with two entries queued.
    bus.out_ready = 1'b0;
    push(3'd1, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01);
    push(3'd1, 2'b10, 2'b00, 1'b0, 1'b0, 2'b10);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_count", 32'(bus.out_count), 32'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_count", 32'(bus.out_count), 32'd0);
    check("async_in_ready", 32'(bus.in_ready), 32'd1);
    check("async_out_y", 32'(bus.out_y), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    push(3'd1, 2'b01, 2'b10, 1'b1, 1'b0, 2'b10);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_y", 32'(bus.out_y), 32'b10);
    @(posedge clk);
    #1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
